serial_word_loader: RTL and testbench
=====================================

Name: serial_word_loader

Overview:
- Serial-to-parallel front end for the register bank.
- Collects WIDTH bits, one per accepted cycle, over a valid/ready serial input.
- Presents the assembled word with a valid/ready output handshake.
- Produces a one-cycle load_enable that drives the enable inputs of the downstream bank of 1-bit enabled registers; word_out drives their data inputs.

Parameters:
WIDTH, 8, number of bits per word (>=1)
MSB_FIRST, 1, 1: first received bit lands in word_out[WIDTH-1]; 0: first bit lands in word_out[0]

Ports:
clk  input  1  rising-edge clock, single domain
reset  input  1  synchronous, active-high reset
serial_in  input  1  serial data bit
serial_valid  input  1  serial_in valid this cycle
serial_ready  output  1  loader can accept a bit this cycle
frame_abort  input  1  discard partially collected word
word_out  output  WIDTH  assembled word, stable while word_valid=1
word_valid  output  1  complete word available
word_ready  input  1  consumer accepts word
load_enable  output  1  high exactly in the word handshake cycle (word_valid & word_ready)
bit_count  output  $clog2(WIDTH+1)  bits collected in current frame
overrun  output  1  sticky: bit offered while word pending
clear_overrun  input  1  clears overrun

Behaviour:
- One clock (clk); reset synchronous, active-high; reset has priority over all other inputs.
- State after a reset edge:
  - state=IDLE, word_out=0, word_valid=0, bit_count=0, overrun=0.
  - load_enable=0, serial_ready=1.
- States:
  - IDLE: bit_count=0, serial_ready=1.
  - SHIFT: 0<bit_count<WIDTH, serial_ready=1.
  - FULL: word_valid=1, serial_ready=0.
- Bit accept = serial_valid & serial_ready, sampled at the clk edge; no bits are lost across gaps in serial_valid.
- Bit placement:
  - MSB_FIRST=1: shift left, new bit enters LSB; after WIDTH bits, the first bit is at [WIDTH-1].
  - MSB_FIRST=0: shift right, new bit enters MSB; after WIDTH bits, the first bit is at [0].
- IDLE:
  - Accepted bit -> SHIFT, bit_count=1.
  - If WIDTH=1, go directly to FULL instead.
- SHIFT: each accepted bit increments bit_count; the accept that completes WIDTH bits -> FULL.
- Word latency and contents:
  - word_valid rises the cycle after the WIDTH-th bit is accepted.
  - bit_count reads 0 in FULL.
  - word_out is updated only on entry to FULL and holds while FULL.
  - word_out keeps its last value after the handshake until the next word completes.
- FULL:
  - load_enable = word_valid & word_ready, combinational.
  - Handshake -> IDLE next cycle: word_valid=0, serial_ready=1.
  - Word_ready held high therefore gives exactly one FULL cycle.
- frame_abort:
  - In IDLE/SHIFT: next state IDLE, bit_count=0; a bit offered in the same cycle is discarded.
  - In FULL: ignored; the pending word is preserved.
- overrun:
  - Set when serial_valid=1 in FULL; the offered bit is dropped.
  - Cleared by clear_overrun or reset; set wins over clear in the same cycle.
- Reset mid-frame or in FULL:
  - Partial or pending word is discarded; no load_enable is generated.
  - word_out returns to 0.
- load_enable never asserts in any cycle where reset=1.

Test Plan:
- WIDTH=8, MSB_FIRST=1, word_ready=1: bits 1,1,0,0,0,0,0,0 on consecutive cycles -> word_out=8'hC0, word_valid and load_enable high for exactly one cycle, the cycle after the 8th bit; serial_ready=1 the following cycle.
- Same stream, MSB_FIRST=0 -> word_out=8'h03.
- Stream 1,0,1,0,0,1,0,1 with serial_valid gaps of 2 cycles between bits -> word_out=8'hA5; bit_count steps 1..7, then reads 0 in FULL.
- Backpressure:
  - Stimulus: complete 8'hA5, word_ready=0 for 3 cycles, serial_valid=1 throughout.
  - Required: serial_ready=0, word_out held at 8'hA5, overrun=1.
  - Then word_ready=1: single load_enable pulse.
  - Then clear_overrun: overrun=0.
- Abort:
  - 3 bits sent, then frame_abort with serial_valid=1 -> bit_count=0.
  - Next 8 bits 0,1,0,1,1,0,1,0 -> word_out=8'h5A with no residue.
  - Abort asserted in FULL -> word retained.
- Reset:
  - Reset after 5 bits -> bit_count=0, word_valid=0, load_enable=0; next full frame is correct.
  - Reset while FULL with word_ready=1 -> no load_enable, word_out=0.

Source files
------------

// File: rtl/serial_word_loader.sv
// rtl/serial_word_loader.sv - serial-to-parallel word loader with valid/ready handshakes
// Collects WIDTH serial bits, presents the word, and pulses load_enable on the word handshake.
module serial_word_loader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_valid,
  output logic             serial_ready,
  input  logic             frame_abort,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             load_enable,
  output logic [CW-1:0]    bit_count,
  output logic             overrun,
  input  logic             clear_overrun
);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_e;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shifted;

  // Accumulator with the incoming bit inserted at the end opposite the first bit.
  generate
    if (WIDTH == 1) begin : g_single
      assign shifted = serial_in;
    end else if (MSB_FIRST) begin : g_msb
      assign shifted = {shift_q[WIDTH-2:0], serial_in};
    end else begin : g_lsb
      assign shifted = {serial_in, shift_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    word_d    = word_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (clear_overrun) overrun_d = 1'b0;
    if (state_q == FULL && serial_valid) overrun_d = 1'b1;
    case (state_q)
      IDLE, SHIFT: begin
        if (frame_abort) begin
          state_d = IDLE;
          count_d = '0;
          shift_d = '0;
        end else if (serial_valid) begin
          shift_d = shifted;
          if (count_q == LAST) begin
            state_d = FULL;
            word_d  = shifted;
            count_d = '0;
          end else begin
            state_d = SHIFT;
            count_d = count_q + CW'(1);
          end
        end
      end
      FULL: begin
        if (word_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      word_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      word_q    <= word_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign serial_ready = (state_q != FULL);
  assign word_valid   = (state_q == FULL);
  // Gated by reset so a word discarded by reset never reaches the register bank.
  assign load_enable  = word_valid & word_ready & ~reset;
  assign word_out     = word_q;
  assign bit_count    = count_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// tb/tb_serial_word_loader.sv - scoreboard bench for serial_word_loader (both bit orders)
// Queue-based reference model predicts words; a negedge monitor checks every cycle.
module tb_serial_word_loader;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, serial_in = 1'b0, serial_valid = 1'b0, frame_abort = 1'b0;
  logic word_ready = 1'b0, clear_overrun = 1'b0;

  logic          m_ready, m_valid, m_le, m_ovr;
  logic [W-1:0]  m_word;
  logic [CW-1:0] m_cnt;
  logic          l_ready, l_valid, l_le, l_ovr;
  logic [W-1:0]  l_word;
  logic [CW-1:0] l_cnt;

  serial_word_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .serial_ready(m_ready), .frame_abort(frame_abort), .word_out(m_word),
    .word_valid(m_valid), .word_ready(word_ready), .load_enable(m_le),
    .bit_count(m_cnt), .overrun(m_ovr), .clear_overrun(clear_overrun)
  );

  serial_word_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .serial_ready(l_ready), .frame_abort(frame_abort), .word_out(l_word),
    .word_valid(l_valid), .word_ready(word_ready), .load_enable(l_le),
    .bit_count(l_cnt), .overrun(l_ovr), .clear_overrun(clear_overrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: collected bits in a queue, words formed arithmetically.
  bit         mq_bits[$];
  logic [7:0] exp_m_q[$];
  logic [7:0] exp_l_q[$];
  logic [7:0] mw_m = '0, mw_l = '0;
  bit         m_pending = 1'b0, m_overrun = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mq_bits.delete();
      exp_m_q.delete();
      exp_l_q.delete();
      m_pending = 1'b0;
      m_overrun = 1'b0;
      mw_m      = '0;
      mw_l      = '0;
    end else if (m_pending) begin
      if (serial_valid) m_overrun = 1'b1;
      else if (clear_overrun) m_overrun = 1'b0;
      if (word_ready) m_pending = 1'b0;
    end else begin
      if (clear_overrun) m_overrun = 1'b0;
      if (frame_abort) mq_bits.delete();
      else if (serial_valid) begin
        mq_bits.push_back(serial_in);
        if (mq_bits.size() == W) begin
          int vm, vl;
          vm = 0;
          vl = 0;
          for (int i = 0; i < W; i++) begin
            vm = vm * 2 + int'(mq_bits[i]);
            vl = vl + int'(mq_bits[i]) * (1 << i);
          end
          mw_m = 8'(vm);
          mw_l = 8'(vl);
          exp_m_q.push_back(mw_m);
          exp_l_q.push_back(mw_l);
          m_pending = 1'b1;
          mq_bits.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    int exp_le;
    exp_le = int'(m_pending && word_ready && !reset);
    chk("msb serial_ready", m_ready, int'(!m_pending));
    chk("lsb serial_ready", l_ready, int'(!m_pending));
    chk("msb word_valid", m_valid, int'(m_pending));
    chk("lsb word_valid", l_valid, int'(m_pending));
    chk("msb bit_count", int'(m_cnt), mq_bits.size());
    chk("lsb bit_count", int'(l_cnt), mq_bits.size());
    chk("msb overrun", m_ovr, int'(m_overrun));
    chk("lsb overrun", l_ovr, int'(m_overrun));
    chk("msb load_enable", m_le, exp_le);
    chk("lsb load_enable", l_le, exp_le);
    chk("msb word_out", int'(m_word), int'(mw_m));
    chk("lsb word_out", int'(l_word), int'(mw_l));
    if (m_le) begin
      chk("msb load has expected word", int'(exp_m_q.size() > 0), 1);
      if (exp_m_q.size() > 0) chk("msb loaded word", int'(m_word), int'(exp_m_q.pop_front()));
    end
    if (l_le) begin
      chk("lsb load has expected word", int'(exp_l_q.size() > 0), 1);
      if (exp_l_q.size() > 0) chk("lsb loaded word", int'(l_word), int'(exp_l_q.pop_front()));
    end
  end

  task automatic cyc(input bit r, input bit sv, input bit si, input bit ab, input bit wr, input bit co);
    reset         = r;
    serial_valid  = sv;
    serial_in     = si;
    frame_abort   = ab;
    word_ready    = wr;
    clear_overrun = co;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v, input int nbits, input int gap, input bit wr);
    for (int i = 7; i > 7 - nbits; i--) begin
      cyc(1'b0, 1'b1, v[i], 1'b0, wr, 1'b0);
      repeat (gap) cyc(1'b0, 1'b0, 1'b0, 1'b0, wr, 1'b0);
    end
  endtask

  task automatic idle(input int n, input bit wr);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, wr, 1'b0);
  endtask

  initial begin
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'hC0, 8, 0, 1'b1);
    idle(2, 1'b1);
    send(8'hA5, 8, 2, 1'b1);
    idle(2, 1'b1);
    // Backpressure with bits offered while the word is pending.
    send(8'hA5, 8, 0, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Abort mid-frame, then abort while full.
    send(8'hE0, 3, 0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send(8'h5A, 8, 0, 1'b1);
    idle(1, 1'b1);
    send(8'h3C, 8, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b1);
    // Reset mid-frame and reset while full with word_ready high.
    send(8'hF8, 5, 0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'h96, 8, 0, 1'b1);
    idle(1, 1'b1);
    send(8'hE7, 8, 0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, 1'($urandom),
          $urandom_range(0, 31) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end
    idle(4, 1'b1);
    chk("scoreboard drained", exp_m_q.size() + exp_l_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
